// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS31 packet generator/checker sequencers.
package prbs_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StAlign,
    StSync,
    StRun,
    StDone
  } prbs_ctrl_state_e;

  localparam int unsigned PRBS_PKT_BEATS = 256;
  localparam int unsigned PRBS_DATA_W    = 32;

  localparam int unsigned PRBS_CLR_CYCLES_DEF  = 8;
  localparam int unsigned PRBS_SYNC_PKTS_DEF   = 2;
  localparam int unsigned PRBS_GUARD_BEATS_DEF = 4;

  function automatic logic [31:0] prbs_sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/prbs_idle_timer.sv
// Idle-cycle counter: counts cycles without a kick while enabled and strobes
// expired_o on the cycle the count reaches all-ones.
module prbs_idle_timer #(
  parameter int unsigned Width = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic kick_i,
  output logic expired_o
);

  localparam logic [Width-1:0] CntMax = '1;

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || kick_i) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Strobe on the increment that lands on all-ones so the owner's flag rises with it.
  assign expired_o = en_i && !kick_i && (cnt_q == CntMax - Width'(1));

endmodule

// File: rtl/prbs_check_ctrl.sv
// Receive-side PRBS31 checker sequencer: clear, align, sync, measured run, report.
// Define PRBS_CHK_CTRL_ERRCNT_EN to count error events and re-arm the checker instead of stopping.
module prbs_check_ctrl
  import prbs_pkg::*;
#(
  parameter int unsigned CLR_CYCLES  = PRBS_CLR_CYCLES_DEF,
  parameter int unsigned SYNC_PKTS   = PRBS_SYNC_PKTS_DEF,
  parameter int unsigned GUARD_BEATS = PRBS_GUARD_BEATS_DEF,
  parameter int unsigned TIMEOUT_W   = 16
) (
  input  logic        rx_user_clk_i,
  input  logic        rx_user_rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] pkt_target_i,
  input  logic        rx_valid_i,
  input  logic        rx_last_i,
  input  logic        chk_err_i,
  output logic        chk_rst_o,
  output logic        chk_valid_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        fail_o,
  output logic        timeout_o,
  output logic [31:0] pkt_cnt_o
`ifdef PRBS_CHK_CTRL_ERRCNT_EN
  ,
  output logic [15:0] err_evt_cnt_o
`endif
);

  localparam logic [7:0] ClrLoad   = 8'(CLR_CYCLES - 1);
  localparam logic [3:0] SyncLast  = 4'(SYNC_PKTS - 1);
  localparam logic [3:0] GuardLoad = 4'(GUARD_BEATS);

  prbs_ctrl_state_e state_q, state_d;

  logic [7:0]  clr_cnt_q, clr_cnt_d;
  logic [3:0]  sync_cnt_q, sync_cnt_d;
  logic [3:0]  guard_q, guard_d;
  logic [31:0] target_q, target_d;
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic        fail_q, fail_d;
  logic        timeout_q, timeout_d;
  logic        pass_q, pass_d;
  logic        chk_pulse_q, chk_pulse_d;

  logic beat_last, post_err, timer_en, idle_expired;

`ifdef PRBS_CHK_CTRL_ERRCNT_EN
  logic        post_err_q;
  logic        err_evt;
  logic [15:0] err_evt_cnt_q, err_evt_cnt_d;
`endif

  assign beat_last = rx_valid_i & rx_last_i;
  assign timer_en  = (state_q == StAlign) || (state_q == StSync) || (state_q == StRun);
  assign post_err  = (state_q == StRun) && (guard_q == 4'd0) && chk_err_i;

`ifdef PRBS_CHK_CTRL_ERRCNT_EN
  assign err_evt = post_err & ~post_err_q;
`endif

  prbs_idle_timer #(
    .Width(TIMEOUT_W)
  ) u_idle_timer (
    .clk_i    (rx_user_clk_i),
    .rst_i    (rx_user_rst_i),
    .en_i     (timer_en),
    .kick_i   (rx_valid_i),
    .expired_o(idle_expired)
  );

  always_ff @(posedge rx_user_clk_i) begin
    if (rx_user_rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    sync_cnt_d  = sync_cnt_q;
    guard_d     = guard_q;
    target_d    = target_q;
    pkt_cnt_d   = pkt_cnt_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    chk_pulse_d = 1'b0;
`ifdef PRBS_CHK_CTRL_ERRCNT_EN
    err_evt_cnt_d = err_evt_cnt_q;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d   = StClr;
          target_d  = pkt_target_i;
          fail_d    = 1'b0;
          timeout_d = 1'b0;
          pkt_cnt_d = '0;
          clr_cnt_d = ClrLoad;
`ifdef PRBS_CHK_CTRL_ERRCNT_EN
          err_evt_cnt_d = '0;
`endif
        end
      end
      StClr: begin
        if (clr_cnt_q == 8'd0) begin
          state_d = StAlign;
        end else begin
          clr_cnt_d = clr_cnt_q - 8'd1;
        end
      end
      StAlign: begin
        if (beat_last) begin
          state_d    = StSync;
          sync_cnt_d = '0;
        end
      end
      StSync: begin
        if (beat_last) begin
          if (sync_cnt_q == SyncLast) begin
            // Clear the checker's counters so the window starts from a trained, clean state.
            state_d     = StRun;
            guard_d     = GuardLoad;
            chk_pulse_d = 1'b1;
          end else begin
            sync_cnt_d = sync_cnt_q + 4'd1;
          end
        end
      end
      StRun: begin
        if (rx_valid_i && (guard_q != 4'd0)) begin
          guard_d = guard_q - 4'd1;
        end
        if (beat_last) begin
          pkt_cnt_d = prbs_sat_inc32(pkt_cnt_q);
          if ((target_q != 32'd0) && (pkt_cnt_d == target_q)) begin
            state_d = StDone;
          end
        end
`ifdef PRBS_CHK_CTRL_ERRCNT_EN
        if (err_evt) begin
          fail_d        = 1'b1;
          chk_pulse_d   = 1'b1;
          err_evt_cnt_d = (err_evt_cnt_q == 16'hFFFF) ? err_evt_cnt_q : err_evt_cnt_q + 16'd1;
        end
`else
        if (post_err) begin
          fail_d  = 1'b1;
          state_d = StDone;
        end
`endif
      end
      default: state_d = StIdle;
    endcase

    // Timeout outranks error/target; abort outranks everything.
    if (idle_expired) begin
      state_d     = StDone;
      timeout_d   = 1'b1;
      fail_d      = fail_q;
      chk_pulse_d = 1'b0;
`ifdef PRBS_CHK_CTRL_ERRCNT_EN
      err_evt_cnt_d = err_evt_cnt_q;
`endif
    end

    if (abort_i) begin
      state_d     = StIdle;
      target_d    = target_q;
      pkt_cnt_d   = pkt_cnt_q;
      fail_d      = fail_q;
      timeout_d   = timeout_q;
      chk_pulse_d = 1'b0;
`ifdef PRBS_CHK_CTRL_ERRCNT_EN
      err_evt_cnt_d = err_evt_cnt_q;
`endif
    end

    pass_d = (state_d == StDone) && !fail_d && !timeout_d;
  end

  always_ff @(posedge rx_user_clk_i) begin
    if (rx_user_rst_i) begin
      clr_cnt_q   <= '0;
      sync_cnt_q  <= '0;
      guard_q     <= '0;
      target_q    <= '0;
      pkt_cnt_q   <= '0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      pass_q      <= 1'b0;
      chk_pulse_q <= 1'b0;
    end else begin
      clr_cnt_q   <= clr_cnt_d;
      sync_cnt_q  <= sync_cnt_d;
      guard_q     <= guard_d;
      target_q    <= target_d;
      pkt_cnt_q   <= pkt_cnt_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      pass_q      <= pass_d;
      chk_pulse_q <= chk_pulse_d;
    end
  end

`ifdef PRBS_CHK_CTRL_ERRCNT_EN
  always_ff @(posedge rx_user_clk_i) begin
    if (rx_user_rst_i) begin
      post_err_q    <= 1'b0;
      err_evt_cnt_q <= '0;
    end else begin
      post_err_q    <= post_err;
      err_evt_cnt_q <= err_evt_cnt_d;
    end
  end

  assign err_evt_cnt_o = err_evt_cnt_q;
`endif

  always_comb begin
    chk_rst_o   = 1'b0;
    chk_valid_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    unique case (state_q)
      StIdle: chk_rst_o = 1'b1;
      StClr: begin
        chk_rst_o = 1'b1;
        busy_o    = 1'b1;
      end
      StAlign: ;
      StSync: begin
        chk_valid_o = rx_valid_i;
        busy_o      = 1'b1;
      end
      StRun: begin
        chk_valid_o = rx_valid_i;
        chk_rst_o   = chk_pulse_q;
        busy_o      = 1'b1;
      end
      StDone: done_o = 1'b1;
      default: chk_rst_o = 1'b1;
    endcase
  end

  assign pass_o    = pass_q;
  assign fail_o    = fail_q;
  assign timeout_o = timeout_q;
  assign pkt_cnt_o = pkt_cnt_q;

endmodule
